// File: rtl/clint_defs.sv
// Shared register offsets, reset constants and small helpers for the CLINT timer.
package clint_defs;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [15:0] off);
    clint_reg_e r;
    case (off)
      CLINT_MSIP:        r = RegMsip;
      CLINT_MTIMECMP_LO: r = RegCmpLo;
      CLINT_MTIMECMP_HI: r = RegCmpHi;
      CLINT_MTIME_LO:    r = RegTimeLo;
      CLINT_MTIME_HI:    r = RegTimeHi;
      default:           r = RegNone;
    endcase
    return r;
  endfunction

  // Byte-lane merge of write data into a 32-bit register half.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Machine timer / software-interrupt block: mtime, mtimecmp and msip on the data bus,
// with a shadowed high half so a LO-then-HI read pair is coherent.
module clint_timer
  import clint_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_rd_en_i,
  input  logic        bus_wr_en_i,
  input  logic [31:0] bus_wr_data_i,
  input  logic [3:0]  bus_wr_strb_i,
  output logic [31:0] bus_rd_data_o,
  output logic        bus_rd_valid_o,
  output logic        bus_err_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o,
  output logic [63:0] mtime_o
);

  logic        sel, access, bad, do_rd, do_wr, mtime_wr, tick;
  clint_reg_e  reg_sel;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic [31:0] rd_data_q, rd_data_d, rd_mux;
  logic        rd_valid_q, err_q, irq_q;

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (mtime_wr),
    .tick(tick)
  );

  always_comb begin
    sel      = (bus_addr_i[31:16] == BASE_ADDR[31:16]);
    access   = sel && (bus_rd_en_i || bus_wr_en_i);
    reg_sel  = clint_decode(bus_addr_i[15:0]);
    bad      = access && ((bus_addr_i[1:0] != 2'b00) || (reg_sel == RegNone) ||
                          (bus_rd_en_i && bus_wr_en_i));
    do_rd    = access && !bad && bus_rd_en_i;
    do_wr    = access && !bad && bus_wr_en_i;
    mtime_wr = do_wr && ((reg_sel == RegTimeLo) || (reg_sel == RegTimeHi));
  end

  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      RegMsip:   rd_mux = {31'h0, msip_q};
      RegCmpLo:  rd_mux = cmp_q[31:0];
      RegCmpHi:  rd_mux = cmp_q[63:32];
      RegTimeLo: rd_mux = mtime_q[31:0];
      RegTimeHi: rd_mux = shadow_vld_q ? shadow_q : mtime_q[63:32];
      default:   rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    mtime_d      = mtime_q;
    cmp_d        = cmp_q;
    msip_d       = msip_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    rd_data_d    = do_rd ? rd_mux : rd_data_q;

    if (tick) mtime_d = mtime_q + 64'd1;

    // A write drops the same-cycle increment; the other half keeps its pre-tick value.
    if (do_wr) begin
      case (reg_sel)
        RegMsip:   if (bus_wr_strb_i[0]) msip_d = bus_wr_data_i[0];
        RegCmpLo:  cmp_d[31:0]  = merge_bytes(cmp_q[31:0], bus_wr_data_i, bus_wr_strb_i);
        RegCmpHi:  cmp_d[63:32] = merge_bytes(cmp_q[63:32], bus_wr_data_i, bus_wr_strb_i);
        RegTimeLo: mtime_d = {mtime_q[63:32],
                              merge_bytes(mtime_q[31:0], bus_wr_data_i, bus_wr_strb_i)};
        RegTimeHi: mtime_d = {merge_bytes(mtime_q[63:32], bus_wr_data_i, bus_wr_strb_i),
                              mtime_q[31:0]};
        default:   ;
      endcase
    end

    if (mtime_wr) begin
      shadow_vld_d = 1'b0;
    end else if (do_rd && (reg_sel == RegTimeLo)) begin
      shadow_d     = mtime_q[63:32];
      shadow_vld_d = 1'b1;
    end else if (do_rd && (reg_sel == RegTimeHi)) begin
      shadow_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q      <= 64'h0;
      cmp_q        <= CLINT_MTIMECMP_RST;
      msip_q       <= 1'b0;
      shadow_q     <= 32'h0;
      shadow_vld_q <= 1'b0;
      rd_data_q    <= 32'h0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      cmp_q        <= cmp_d;
      msip_q       <= msip_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= do_rd;
      err_q        <= bad;
      irq_q        <= (mtime_q >= cmp_q);
    end
  end

  assign bus_rd_data_o  = rd_data_q;
  assign bus_rd_valid_o = rd_valid_q;
  assign bus_err_o      = err_q;
  assign timer_irq_o    = irq_q;
  assign soft_irq_o     = msip_q;
  assign mtime_o        = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) on a shared bus, checked every
// cycle against a model where mtime is a closed-form function of elapsed clock edges.
module tb_clint_timer;

  localparam logic [15:0] BaseHi   = 16'h0200;
  localparam logic [31:0] Base     = 32'h0200_0000;
  localparam logic [15:0] OffMsip  = 16'h0000;
  localparam logic [15:0] OffCmpLo = 16'h4000;
  localparam logic [15:0] OffCmpHi = 16'h4004;
  localparam logic [15:0] OffTLo   = 16'hBFF8;
  localparam logic [15:0] OffTHi   = 16'hBFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  strb = '0;

  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        err    [2];
  logic        tirq   [2];
  logic        sirq   [2];
  logic [63:0] mt_o   [2];

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus_addr_i(addr), .bus_rd_en_i(rd_en), .bus_wr_en_i(wr_en),
    .bus_wr_data_i(wdata), .bus_wr_strb_i(strb), .bus_rd_data_o(rdata[0]),
    .bus_rd_valid_o(rvalid[0]), .bus_err_o(err[0]), .timer_irq_o(tirq[0]),
    .soft_irq_o(sirq[0]), .mtime_o(mt_o[0])
  );

  clint_timer #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus_addr_i(addr), .bus_rd_en_i(rd_en), .bus_wr_en_i(wr_en),
    .bus_wr_data_i(wdata), .bus_wr_strb_i(strb), .bus_rd_data_o(rdata[1]),
    .bus_rd_valid_o(rvalid[1]), .bus_err_o(err[1]), .timer_irq_o(tirq[1]),
    .soft_irq_o(sirq[1]), .mtime_o(mt_o[1])
  );

  int nchk = 0;
  int nfail = 0;
  longint unsigned ecnt = 0;

  // Model: mtime after edge e = base + (e - base_e) / div.
  longint unsigned base_e [2];
  logic [63:0] base [2], cmp [2], prev_mt [2], prev_cmp [2];
  logic        msip_m [2], shv [2], exp_valid [2], exp_err [2], exp_irq [2];
  logic [31:0] shadow [2], last_rd [2];

  function automatic longint unsigned div_of(int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [63:0] mt(int i, longint unsigned e);
    return base[i] + 64'((e - base_e[i]) / div_of(i));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk;
    for (int i = 0; i < 2; i++) begin
      prev_mt[i]  = mt(i, ecnt);
      prev_cmp[i] = cmp[i];
    end
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic model(logic r, logic [31:0] a, logic re, logic we, logic [31:0] d,
                       logic [3:0] s);
    logic [15:0] off;
    logic [63:0] cur;
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      exp_err[i]   = 1'b0;
      if (r) begin
        base[i] = '0; base_e[i] = ecnt; cmp[i] = '1; msip_m[i] = 1'b0;
        shadow[i] = '0; shv[i] = 1'b0; last_rd[i] = '0; exp_irq[i] = 1'b0;
        continue;
      end
      exp_irq[i] = (prev_mt[i] >= prev_cmp[i]);
      if (a[31:16] != BaseHi || !(re || we)) continue;
      off = a[15:0];
      if (a[1:0] != 2'b00 || !(off inside {OffMsip, OffCmpLo, OffCmpHi, OffTLo, OffTHi}) ||
          (re && we)) begin
        exp_err[i] = 1'b1;
        continue;
      end
      cur = prev_mt[i];
      if (we) begin
        case (off)
          OffMsip:  if (s[0]) msip_m[i] = d[0];
          OffCmpLo: cmp[i][31:0]  = merge(cmp[i][31:0], d, s);
          OffCmpHi: cmp[i][63:32] = merge(cmp[i][63:32], d, s);
          OffTLo:   begin base[i] = {cur[63:32], merge(cur[31:0], d, s)};
                          base_e[i] = ecnt; shv[i] = 1'b0; end
          default:  begin base[i] = {merge(cur[63:32], d, s), cur[31:0]};
                          base_e[i] = ecnt; shv[i] = 1'b0; end
        endcase
      end else begin
        case (off)
          OffMsip:  v = {31'h0, msip_m[i]};
          OffCmpLo: v = cmp[i][31:0];
          OffCmpHi: v = cmp[i][63:32];
          OffTLo:   begin v = cur[31:0]; shadow[i] = cur[63:32]; shv[i] = 1'b1; end
          default:  begin v = shv[i] ? shadow[i] : cur[63:32]; shv[i] = 1'b0; end
        endcase
        last_rd[i]   = v;
        exp_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_valid%0d", i), 64'(rvalid[i]), 64'(exp_valid[i]));
      chk($sformatf("err%0d", i), 64'(err[i]), 64'(exp_err[i]));
      chk($sformatf("rd_data%0d", i), 64'(rdata[i]), 64'(last_rd[i]));
      chk($sformatf("timer_irq%0d", i), 64'(tirq[i]), 64'(exp_irq[i]));
      chk($sformatf("soft_irq%0d", i), 64'(sirq[i]), 64'(msip_m[i]));
      chk($sformatf("mtime%0d", i), mt_o[i], mt(i, ecnt));
    end
  endtask

  task automatic cyc(logic r, logic [31:0] a, logic re, logic we, logic [31:0] d,
                     logic [3:0] s);
    rst = r; addr = a; rd_en = re; wr_en = we; wdata = d; strb = s;
    tick_clk();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    model(r, a, re, we, d, s);
    check_all();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic rd(logic [15:0] off);
    cyc(1'b0, Base | 32'(off), 1'b1, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic wr(logic [15:0] off, logic [31:0] d, logic [3:0] s);
    cyc(1'b0, Base | 32'(off), 1'b0, 1'b1, d, s);
  endtask

  initial begin
    logic [31:0] hi_before;
    logic [15:0] offs [5];
    int kind;
    offs = '{OffMsip, OffCmpLo, OffCmpHi, OffTLo, OffTHi};

    // Reset and initial reads
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("reset_mtime", mt_o[0], 64'h0);
    rd(OffTLo);
    rd(OffTHi);
    rd(OffCmpHi);
    chk("cmp_hi_reset", 64'(rdata[0]), 64'hFFFF_FFFF);
    chk("irq_reset", 64'(tirq[0]), 64'h0);
    chk("sirq_reset", 64'(sirq[0]), 64'h0);

    // Low-half wrap and coherent high read
    wr(OffTHi, 32'h0, 4'hF);
    wr(OffTLo, 32'hFFFF_FFFE, 4'hF);
    idle(3);
    rd(OffTLo);
    chk("lo_wrapped", 64'(rdata[0]), 64'h1);
    idle(2);
    rd(OffTHi);
    chk("hi_shadow", 64'(rdata[0]), 64'h1);

    // Timer interrupt rise and fall latency
    wr(OffCmpLo, 32'h40, 4'hF);
    wr(OffTHi, 32'h0, 4'hF);
    wr(OffCmpHi, 32'h0, 4'hF);
    wr(OffTLo, 32'h3E, 4'hF);
    idle(1);
    chk("irq_w1", 64'(tirq[0]), 64'h0);
    idle(1);
    chk("irq_w2", 64'(tirq[0]), 64'h0);
    idle(1);
    chk("irq_rise", 64'(tirq[0]), 64'h1);
    wr(OffCmpHi, 32'hFFFF_FFFF, 4'hF);
    chk("irq_hold", 64'(tirq[0]), 64'h1);
    idle(1);
    chk("irq_fall", 64'(tirq[0]), 64'h0);

    // MSIP
    wr(OffMsip, 32'hFFFF_FFFF, 4'hF);
    chk("msip_set", 64'(sirq[0]), 64'h1);
    rd(OffMsip);
    chk("msip_read", 64'(rdata[0]), 64'h1);
    wr(OffMsip, 32'h0, 4'h0);
    chk("msip_nostrb", 64'(sirq[0]), 64'h1);

    // Error and unselected accesses
    cyc(1'b0, Base | 32'h2, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("err_misalign", 64'(err[0]), 64'h1);
    chk("err_misalign_nv", 64'(rvalid[0]), 64'h0);
    idle(1);
    chk("err_pulse", 64'(err[0]), 64'h0);
    wr(16'h1000, 32'hDEAD_BEEF, 4'hF);
    chk("err_unmapped", 64'(err[0]), 64'h1);
    cyc(1'b0, Base | 32'(OffMsip), 1'b1, 1'b1, 32'h0, 4'hF);
    chk("err_rdwr", 64'(err[0]), 64'h1);
    chk("err_rdwr_msip", 64'(sirq[0]), 64'h1);
    cyc(1'b0, 32'h0300_0000, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("unsel_err", 64'(err[0]), 64'h0);
    chk("unsel_valid", 64'(rvalid[0]), 64'h0);
    cyc(1'b0, 32'h0300_0000, 1'b0, 1'b1, 32'h0, 4'hF);
    chk("unsel_wr_msip", 64'(sirq[0]), 64'h1);

    // TICK_DIV=4: MTIME_LO write landing on a tick edge
    for (int k = 0; k < 8 && ((ecnt + 1 - base_e[1]) % 4) != 0; k++) idle(1);
    chk("collide_aligned", (ecnt + 1 - base_e[1]) % 4, 64'h0);
    hi_before = mt_o[1][63:32];
    wr(OffTLo, 32'h1234_5678, 4'hF);
    for (int k = 0; k < 4; k++) begin
      chk("collide_hold", mt_o[1], {hi_before, 32'h1234_5678});
      idle(1);
    end
    chk("collide_inc", mt_o[1], {hi_before, 32'h1234_5679});

    // Reset during a pending read
    rd(OffCmpLo);
    cyc(1'b1, Base | 32'(OffTLo), 1'b1, 1'b0, 32'h0, 4'h0);
    chk("rst_abort_valid", 64'(rvalid[0]), 64'h0);
    chk("rst_abort_data", 64'(rdata[0]), 64'h0);
    idle(1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 20));
      if (kind <= 3) idle(1);
      else if (kind <= 9) rd(offs[$urandom_range(0, 4)]);
      else if (kind <= 15) wr(offs[$urandom_range(0, 4)], $urandom, 4'($urandom));
      else if (kind == 16) cyc(1'b0, Base | 32'($urandom_range(1, 3)), 1'b1, 1'b0, 0, 0);
      else if (kind == 17) wr(16'h2000, $urandom, 4'hF);
      else if (kind == 18) cyc(1'b0, Base | 32'(offs[$urandom_range(0, 4)]), 1'b1, 1'b1,
                               $urandom, 4'hF);
      else if (kind == 19) cyc(1'b0, 32'h0300_0000 | 32'(offs[$urandom_range(0, 4)]),
                               1'($urandom), 1'b1, $urandom, 4'hF);
      else if ($urandom_range(0, 9) == 0) cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      else idle(1);
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
